// File: rtl/matmul_pkg.sv
// Shared constants and FSM state encoding for the 16x16 integer matrix multiplier.
package matmul_pkg;
  localparam int N      = 16;
  localparam int ADDR_W = 8;
  localparam int DATA_W = 32;
  localparam int CNT_W  = 4;
  localparam int STAGES = 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } state_t;
endpackage

// File: rtl/matmul_mac.sv
// 32-bit multiply-accumulate; clr makes the current product the first term of a new sum.
module matmul_mac
  import matmul_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              clr,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] sum
);
  logic [DATA_W-1:0] acc;
  logic [DATA_W-1:0] prod;

  // Low half of the product only; wrap-around makes signed/unsigned identical.
  assign prod = a * b;
  assign sum  = (clr ? '0 : acc) + prod;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  acc <= '0;
    else if (en) acc <= sum;
  end
endmodule

// File: rtl/matmul.sv
// C = A x B over 16x16 32-bit matrices: one (i,j,k) read pair per cycle, one C write per 16 cycles.
module matmul
  import matmul_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              tstart,
  output logic [ADDR_W-1:0] v0_addr,
  output logic              v0_rd_en,
  input  logic [DATA_W-1:0] v0_rd_data,
  output logic [ADDR_W-1:0] v1_addr,
  output logic              v1_rd_en,
  input  logic [DATA_W-1:0] v1_rd_data,
  output logic [ADDR_W-1:0] v2_addr,
  output logic              v2_wr_en,
  output logic [DATA_W-1:0] v2_wr_data
);
  state_t           state;
  logic [CNT_W-1:0] i, j, k;
  logic [CNT_W-1:0] i_d, j_d;
  logic             k_first_d, k_last_d;
  logic [STAGES:0]  vld_pipe;
  logic             last_rd;
  logic             wr;
  logic [DATA_W-1:0] sum;

  assign last_rd = &{i, j, k};

  // Counters sit at zero outside RUN, so the read addresses idle at 0 with no gating.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      i         <= '0;
      j         <= '0;
      k         <= '0;
      i_d       <= '0;
      j_d       <= '0;
      k_first_d <= 1'b0;
      k_last_d  <= 1'b0;
      vld_pipe  <= '0;
    end else begin
      vld_pipe[STAGES:1] <= vld_pipe[STAGES-1:0];
      i_d       <= i;
      j_d       <= j;
      k_first_d <= (k == '0);
      k_last_d  <= (k == CNT_W'(N-1));
      case (state)
        IDLE: begin
          if (tstart) begin
            state       <= RUN;
            vld_pipe[0] <= 1'b1;
          end
        end
        RUN: begin
          {i, j, k} <= {i, j, k} + 1'b1;
          if (last_rd) begin
            state       <= FLUSH;
            vld_pipe[0] <= 1'b0;
          end
        end
        FLUSH:   state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign v0_rd_en = vld_pipe[0];
  assign v1_rd_en = vld_pipe[0];
  assign v0_addr  = {i, k};
  assign v1_addr  = {k, j};

  matmul_mac u_mac (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (vld_pipe[STAGES]),
    .clr   (k_first_d),
    .a     (v0_rd_data),
    .b     (v1_rd_data),
    .sum   (sum)
  );

  // The final term lands in the same cycle as the write, so C leaves straight from the adder.
  assign wr         = vld_pipe[STAGES] & k_last_d;
  assign v2_wr_en   = wr;
  assign v2_addr    = wr ? {i_d, j_d} : '0;
  assign v2_wr_data = wr ? sum : '0;
endmodule

// File: tb/tb_matmul.sv
// Directed bench for matmul: address-valued memories, cadence, wrap, restart and reset cases.
module tb_matmul;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        tstart = 1'b0;
  logic [7:0]  v0_addr, v1_addr, v2_addr;
  logic        v0_rd_en, v1_rd_en, v2_wr_en;
  logic [31:0] v0_rd_data = '0, v1_rd_data = '0, v2_wr_data;

  bit          ff_mode = 1'b0;
  int          checks = 0, errors = 0;
  int          rd_cnt, rd_gap, addr_bad, wr_cnt, wr_time_bad, wr_after, rst_nz, quiet_nz;
  logic [31:0] got [256];
  logic [15:0] pair [4];

  matmul dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .tstart     (tstart),
    .v0_addr    (v0_addr),
    .v0_rd_en   (v0_rd_en),
    .v0_rd_data (v0_rd_data),
    .v1_addr    (v1_addr),
    .v1_rd_en   (v1_rd_en),
    .v1_rd_data (v1_rd_data),
    .v2_addr    (v2_addr),
    .v2_wr_en   (v2_wr_en),
    .v2_wr_data (v2_wr_data)
  );

  always #5 clk = ~clk;

  // Memory model: data is the zero-extended address, one cycle after the request.
  always @(posedge clk) begin
    v0_rd_data <= ff_mode ? 32'hFFFF_FFFF : {24'd0, v0_addr};
    v1_rd_data <= ff_mode ? 32'hFFFF_FFFF : {24'd0, v1_addr};
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] cexp(input int i, input int j, input bit ff);
    logic [31:0] s, a, b;
    s = '0;
    for (int k = 0; k < 16; k++) begin
      a = ff ? 32'hFFFF_FFFF : 32'(i * 16 + k);
      b = ff ? 32'hFFFF_FFFF : 32'(k * 16 + j);
      s = s + a * b;
    end
    return s;
  endfunction

  function automatic int count_bad(input bit ff);
    int bad = 0;
    for (int e = 0; e < 256; e++)
      if (got[e] !== cexp(e / 16, e % 16, ff)) bad++;
    return bad;
  endfunction

  task automatic start_pulse();
    @(negedge clk);
    tstart = 1'b1;
  endtask

  // Observes cycles R0..R4097 of a run; optional mid-run pulse, reset, or back-to-back start.
  task automatic collect(input int pulse_at, input int rst_at, input bit b2b);
    int i, j, k;
    rd_cnt = 0; rd_gap = 0; addr_bad = 0; wr_cnt = 0;
    wr_time_bad = 0; wr_after = 0; rst_nz = 0;
    for (int e = 0; e < 256; e++) got[e] = 'x;
    for (int n = 0; n < 4098; n++) begin
      @(negedge clk);
      tstart = (n == pulse_at) || (b2b && n == 4097);
      if (n == rst_at) rst_n = 1'b0;
      if (n == rst_at + 3) rst_n = 1'b1;
      #1;
      if (n == rst_at && (v0_rd_en || v1_rd_en || v2_wr_en || v0_addr != 0 ||
                          v1_addr != 0 || v2_addr != 0 || v2_wr_data != 0)) rst_nz++;
      i = n / 256; j = (n / 16) % 16; k = n % 16;
      if (v0_rd_en) begin
        if (n != rd_cnt) rd_gap++;
        rd_cnt++;
        if (!v1_rd_en || v0_addr != 8'(i * 16 + k) || v1_addr != 8'(k * 16 + j)) addr_bad++;
      end else if (v1_rd_en) addr_bad++;
      if (n == 0)  pair[0] = {v0_addr, v1_addr};
      if (n == 1)  pair[1] = {v0_addr, v1_addr};
      if (n == 15) pair[2] = {v0_addr, v1_addr};
      if (n == 16) pair[3] = {v0_addr, v1_addr};
      if (v2_wr_en) begin
        wr_cnt++;
        if (n != 16 * (int'(v2_addr) + 1)) wr_time_bad++;
        if (n >= rst_at) wr_after++;
        got[v2_addr] = v2_wr_data;
      end
    end
  endtask

  initial begin
    // Reset and idle behaviour
    repeat (3) @(negedge clk);
    chk("rst_enables", {29'd0, v0_rd_en, v1_rd_en, v2_wr_en}, 32'd0);
    chk("rst_addrs", {8'd0, v0_addr, v1_addr, v2_addr}, 32'd0);
    chk("rst_wdata", v2_wr_data, 32'd0);
    rst_n = 1'b1;
    quiet_nz = 0;
    repeat (100) begin
      @(negedge clk);
      if (v0_rd_en || v1_rd_en || v2_wr_en || v0_addr != 0 || v1_addr != 0 ||
          v2_addr != 0 || v2_wr_data != 0) quiet_nz++;
    end
    chk("idle_quiet", quiet_nz, 0);

    // Single run
    start_pulse();
    collect(-1, 99999, 1'b0);
    chk("run_rd_cycles", rd_cnt, 4096);
    chk("run_rd_gap", rd_gap, 0);
    chk("run_addr_bad", addr_bad, 0);
    chk("addr_r0", {16'd0, pair[0]}, 32'h0000);
    chk("addr_r1", {16'd0, pair[1]}, 32'h0110);
    chk("addr_r15", {16'd0, pair[2]}, 32'h0FF0);
    chk("addr_r16", {16'd0, pair[3]}, 32'h0001);
    chk("run_wr_cnt", wr_cnt, 256);
    chk("run_wr_timing", wr_time_bad, 0);
    chk("c00", got[0], 32'd19840);
    chk("c01", got[1], 32'd19960);
    chk("c10", got[16], 32'd50560);
    chk("c1515", got[255], 32'd540040);
    chk("run_values", count_bad(1'b0), 0);
    chk("post_idle", {29'd0, v0_rd_en, v1_rd_en, v2_wr_en}, 32'd0);

    // Overflow wrap
    ff_mode = 1'b1;
    start_pulse();
    collect(-1, 99999, 1'b0);
    chk("wrap_wr_cnt", wr_cnt, 256);
    chk("wrap_c37", got[37], 32'd16);
    chk("wrap_values", count_bad(1'b1), 0);
    ff_mode = 1'b0;

    // tstart re-pulsed during RUN
    start_pulse();
    collect(100, 99999, 1'b0);
    chk("repulse_rd_cycles", rd_cnt, 4096);
    chk("repulse_wr_cnt", wr_cnt, 256);
    chk("repulse_values", count_bad(1'b0), 0);

    // Reset mid-run, then a full run
    start_pulse();
    collect(-1, 2000, 1'b0);
    chk("midrst_outs_zero", rst_nz, 0);
    chk("midrst_no_writes", wr_after, 0);
    chk("midrst_wr_before", wr_cnt, 124);
    chk("midrst_rd_stop", rd_cnt, 2000);
    start_pulse();
    collect(-1, 99999, 1'b0);
    chk("after_rst_wr_cnt", wr_cnt, 256);
    chk("after_rst_values", count_bad(1'b0), 0);

    // Back-to-back runs
    start_pulse();
    collect(-1, 99999, 1'b1);
    chk("b2b_first_wr_cnt", wr_cnt, 256);
    collect(-1, 99999, 1'b0);
    chk("b2b_rd_cycles", rd_cnt, 4096);
    chk("b2b_rd_gap", rd_gap, 0);
    chk("b2b_wr_cnt", wr_cnt, 256);
    chk("b2b_values", count_bad(1'b0), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
